// File: rtl/mod_add_sub.sv
// Multi-cycle modular adder/subtractor.
// Works on LIMB-wide slices, least significant slice first, one slice per
// clock. Two carry/borrow chains run side by side. One chain makes the raw
// sum or difference. The other makes the same value with m taken off
// (add mode) or put back (subtract mode). A final flag test picks which of
// the two full-width values becomes the modular result.
// The slice shifters assume at least two limbs (WIDTH >= 2*LIMB).

module mod_add_sub #(
  parameter int WIDTH = 1024,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int NL = WIDTH / LIMB;
  localparam int CW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NL - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  // Limb add with carry-in; bit LIMB of the return value is the carry-out.
  function automatic logic [LIMB:0] limb_add(input logic [LIMB-1:0] x,
                                             input logic [LIMB-1:0] y,
                                             input logic            cin);
    return {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
  endfunction

  // Limb subtract with borrow-in; bit LIMB of the return value is the borrow-out.
  function automatic logic [LIMB:0] limb_sub(input logic [LIMB-1:0] x,
                                             input logic [LIMB-1:0] y,
                                             input logic            bin);
    return {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, bin};
  endfunction

  // Decides whether the corrected value replaces the raw value.
  // Add: the sum reached m when it carried out of WIDTH bits, or when
  //      taking m off did not borrow.
  // Sub: a borrow out of a-b means the difference went negative, so m
  //      has to be added back.
  function automatic logic select_alt(input logic sub,
                                      input logic flag_raw,
                                      input logic flag_alt);
    if (sub) return flag_raw;
    return flag_raw | ~flag_alt;
  endfunction

  state_t state, state_nxt;

  logic [CW-1:0]    limb_cnt;
  logic             sub_mode;
  logic             chain_raw;   // c_s (add) or b_d (sub)
  logic             chain_alt;   // b_t (add) or c_e (sub)

  logic [WIDTH-1:0] a_p1, b_p1, m_p1;
  logic [WIDTH-1:0] raw_p1, alt_p1;

  logic             accept;
  logic             vld_p0;
  logic [LIMB:0]    raw_p0, alt_p0;
  logic [WIDTH-1:0] raw_nxt_p0, alt_nxt_p0;
  logic             use_alt_p0;

  assign accept = start && (state != CALC);
  assign vld_p0 = (state == CALC);

  // ---- stage p0: combinational limb arithmetic on the current low slice ----

  // Both chains for the current limb, and the shifted-in full-width values
  always_comb begin
    raw_p0 = '0;
    alt_p0 = '0;
    if (sub_mode) begin
      raw_p0 = limb_sub(a_p1[LIMB-1:0], b_p1[LIMB-1:0], chain_raw);
      alt_p0 = limb_add(raw_p0[LIMB-1:0], m_p1[LIMB-1:0], chain_alt);
    end else begin
      raw_p0 = limb_add(a_p1[LIMB-1:0], b_p1[LIMB-1:0], chain_raw);
      alt_p0 = limb_sub(raw_p0[LIMB-1:0], m_p1[LIMB-1:0], chain_alt);
    end
    raw_nxt_p0 = {raw_p0[LIMB-1:0], raw_p1[WIDTH-1:LIMB]};
    alt_nxt_p0 = {alt_p0[LIMB-1:0], alt_p1[WIDTH-1:LIMB]};
    use_alt_p0 = select_alt(sub_mode, raw_p0[LIMB], alt_p0[LIMB]);
  end

  // ---- stage p1: operand shifters and partial-result shifters ----

  // Latch operands on accept; during CALC shift the operands down one limb
  // and shift the new result limbs in from the top
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1 <= in_a;
      b_p1 <= in_b;
      m_p1 <= in_m;
    end else if (vld_p0) begin
      a_p1   <= a_p1 >> LIMB;
      b_p1   <= b_p1 >> LIMB;
      m_p1   <= m_p1 >> LIMB;
      raw_p1 <= raw_nxt_p0;
      alt_p1 <= alt_nxt_p0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: start is accepted only outside CALC
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (limb_cnt == LAST) state_nxt = FIN;
      FIN:  state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control, chain flags, handshake outputs and the result write
  always_ff @(posedge clk) begin
    if (!resetn) begin
      limb_cnt  <= '0;
      sub_mode  <= 1'b0;
      chain_raw <= 1'b0;
      chain_alt <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= (state_nxt == FIN);
      busy <= (state_nxt == CALC);
      if (accept) begin
        limb_cnt  <= '0;
        sub_mode  <= subtract;
        chain_raw <= 1'b0;
        chain_alt <= 1'b0;
      end else if (vld_p0) begin
        chain_raw <= raw_p0[LIMB];
        chain_alt <= alt_p0[LIMB];
        if (limb_cnt == LAST) begin
          result <= use_alt_p0 ? alt_nxt_p0 : raw_nxt_p0;
        end else begin
          limb_cnt <= limb_cnt + 1'b1;
        end
      end
    end
  end

endmodule
